// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game lane logic: FSM states, grades,
// keyboard scan codes and default screen geometry.
package rhythm_pkg;

    typedef enum logic [1:0] {
        HALTED,
        WAIT,
        FALL,
        DONE
    } dropper_state_t;

    typedef enum logic [1:0] {
        NONE,
        MISS,
        HIT,
        PERFECT
    } grade_t;

    localparam logic [7:0] KEY_SPACE = 8'h2c;
    localparam logic [7:0] KEY_ESC   = 8'h01;
    localparam logic [7:0] KEY_RIGHT = 8'h4f;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    localparam int Y_MAX_DEF   = 400;
    localparam int ARROW_H_DEF = 40;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hff) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/arrow_lane_dropper_if.sv
// Bundle between the keyboard/renderer side and one lane dropper.
// The dropper takes the slave view; whoever drives keys and reads the lane takes master.
interface arrow_lane_dropper_if #(
    parameter int NUM_NOTES = 4,
    parameter int CNT_W     = 12
);

    logic [7:0]                 keycode;
    logic [7:0]                 keycode_second;
    logic [NUM_NOTES*CNT_W-1:0] spawn_frames;
    logic [9:0]                 drop_x;
    logic [9:0]                 drop_y;
    logic                       visible;
    logic                       hit_pulse;
    logic                       perfect_pulse;
    logic                       miss_pulse;
    logic [7:0]                 hit_count;
    logic [7:0]                 miss_count;
    logic                       done;

    modport slave (
        input  keycode, keycode_second, spawn_frames,
        output drop_x, drop_y, visible, hit_pulse, perfect_pulse, miss_pulse,
               hit_count, miss_count, done
    );

    modport master (
        output keycode, keycode_second, spawn_frames,
        input  drop_x, drop_y, visible, hit_pulse, perfect_pulse, miss_pulse,
               hit_count, miss_count, done
    );

endinterface

// File: rtl/lane_key_detect.sv
// Matches the lane, start and restart keys on either keycode input.
// With DROPPER_KEY_EDGE_EN defined the lane key only counts on the frame it first appears.
module lane_key_detect
    import rhythm_pkg::*;
#(
    parameter logic [7:0] KEY_CODE    = KEY_DOWN,
    parameter logic [7:0] START_KEY   = KEY_SPACE,
    parameter logic [7:0] RESTART_KEY = KEY_ESC
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode_second,
    output logic       key_hit,
    output logic       start_req,
    output logic       restart_req
);

    logic key_present;

    assign key_present = (keycode == KEY_CODE)    || (keycode_second == KEY_CODE);
    assign start_req   = (keycode == START_KEY)   || (keycode_second == START_KEY);
    assign restart_req = (keycode == RESTART_KEY) || (keycode_second == RESTART_KEY);

`ifdef DROPPER_KEY_EDGE_EN
    logic key_prev;

    // Remembers whether the lane key was already down last frame, so a held key fires once.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            key_prev <= 1'b0;
        end else begin
            key_prev <= key_present;
        end
    end

    assign key_hit = key_present && !key_prev;
`else
    logic unused_clk_rst;

    // Level-sensitive matching needs no state; clock and reset only feed the edge register.
    assign unused_clk_rst = frame_clk ^ Reset;
    assign key_hit        = key_present;
`endif

endmodule

// File: rtl/arrow_lane_dropper.sv
// Single-lane note engine: spawns NUM_NOTES arrows on schedule, drops them and grades key presses.
// Optional DROPPER_KEY_EDGE_EN makes the lane key edge-triggered (see lane_key_detect).
module arrow_lane_dropper
    import rhythm_pkg::*;
#(
    parameter int         LANE_X      = 220,
    parameter int         Y_START     = 100,
    parameter int         Y_MAX       = Y_MAX_DEF,
    parameter int         ARROW_H     = ARROW_H_DEF,
    parameter int         HIT_LO      = 340,
    parameter int         PERF_LO     = 360,
    parameter int         PERF_HI     = 380,
    parameter int         SPEED       = 1,
    parameter logic [7:0] KEY_CODE    = KEY_DOWN,
    parameter logic [7:0] START_KEY   = KEY_SPACE,
    parameter logic [7:0] RESTART_KEY = KEY_ESC,
    parameter int         NUM_NOTES   = 4,
    parameter int         CNT_W       = 12
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    arrow_lane_dropper_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_NOTES + 1);

    dropper_state_t   state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [9:0]       drop_y_q, drop_y_d;
    logic             visible_q, visible_d;
    logic             hit_pulse_q, hit_pulse_d;
    logic             perfect_pulse_q, perfect_pulse_d;
    logic             miss_pulse_q, miss_pulse_d;
    logic [7:0]       hit_count_q, hit_count_d;
    logic [7:0]       miss_count_q, miss_count_d;
    logic             done_q, done_d;

    logic             key_hit;
    logic             start_req;
    logic             restart_req;
    logic [10:0]      bottom;
    logic [CNT_W-1:0] spawn_sel;
    logic [CNT_W-1:0] counter_inc;
    logic [IDX_W-1:0] index_inc;
    grade_t           grade;
    logic             abort;

    lane_key_detect #(
        .KEY_CODE    (KEY_CODE),
        .START_KEY   (START_KEY),
        .RESTART_KEY (RESTART_KEY)
    ) u_key_detect (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (bus.keycode),
        .keycode_second (bus.keycode_second),
        .key_hit        (key_hit),
        .start_req      (start_req),
        .restart_req    (restart_req)
    );

    // Bottom is formed at 11 bits so a large drop_y plus the arrow height cannot wrap.
    always_comb begin
        bottom      = {1'b0, drop_y_q} + 11'(ARROW_H);
        counter_inc = (counter_q == '1) ? counter_q : counter_q + 1'b1;
        index_inc   = index_q + IDX_W'(1);
        spawn_sel   = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (index_q == IDX_W'(i)) begin
                spawn_sel = bus.spawn_frames[i*CNT_W +: CNT_W];
            end
        end

        grade = NONE;
        if (bottom >= 11'(Y_MAX)) begin
            grade = MISS;
        end else if (key_hit && (bottom >= 11'(HIT_LO))) begin
            if ((bottom >= 11'(PERF_LO)) && (bottom < 11'(PERF_HI))) begin
                grade = PERFECT;
            end else begin
                grade = HIT;
            end
        end
    end

    // Next-state and datapath; a restart in WAIT/FALL/DONE collapses everything back to HALTED.
    always_comb begin
        state_d         = state_q;
        counter_d       = counter_q;
        index_d         = index_q;
        drop_y_d        = drop_y_q;
        visible_d       = visible_q;
        hit_pulse_d     = 1'b0;
        perfect_pulse_d = 1'b0;
        miss_pulse_d    = 1'b0;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        done_d          = done_q;
        abort           = 1'b0;

        case (state_q)
            HALTED: begin
                abort = 1'b1;
                if (start_req && !restart_req) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (restart_req) begin
                    abort   = 1'b1;
                    state_d = HALTED;
                end else begin
                    counter_d = counter_inc;
                    if (counter_q >= spawn_sel) begin
                        state_d   = FALL;
                        drop_y_d  = 10'(Y_START);
                        visible_d = 1'b1;
                    end
                end
            end

            FALL: begin
                if (restart_req) begin
                    abort   = 1'b1;
                    state_d = HALTED;
                end else begin
                    counter_d = counter_inc;
                    if (grade == NONE) begin
                        drop_y_d = drop_y_q + 10'(SPEED);
                    end else begin
                        visible_d       = 1'b0;
                        miss_pulse_d    = (grade == MISS);
                        hit_pulse_d     = (grade == HIT) || (grade == PERFECT);
                        perfect_pulse_d = (grade == PERFECT);
                        if (grade == MISS) begin
                            miss_count_d = sat_inc8(miss_count_q);
                        end else begin
                            hit_count_d = sat_inc8(hit_count_q);
                        end
                        index_d = index_inc;
                        if (index_inc == IDX_W'(NUM_NOTES)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end

            DONE: begin
                visible_d = 1'b0;
                done_d    = 1'b1;
                if (restart_req) begin
                    abort   = 1'b1;
                    state_d = HALTED;
                end
            end

            default: begin
                abort   = 1'b1;
                state_d = HALTED;
            end
        endcase

        if (abort) begin
            counter_d    = '0;
            index_d      = '0;
            drop_y_d     = 10'(Y_START);
            visible_d    = 1'b0;
            hit_count_d  = 8'd0;
            miss_count_d = 8'd0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q         <= HALTED;
            counter_q       <= '0;
            index_q         <= '0;
            drop_y_q        <= 10'(Y_START);
            visible_q       <= 1'b0;
            hit_pulse_q     <= 1'b0;
            perfect_pulse_q <= 1'b0;
            miss_pulse_q    <= 1'b0;
            hit_count_q     <= 8'd0;
            miss_count_q    <= 8'd0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            index_q         <= index_d;
            drop_y_q        <= drop_y_d;
            visible_q       <= visible_d;
            hit_pulse_q     <= hit_pulse_d;
            perfect_pulse_q <= perfect_pulse_d;
            miss_pulse_q    <= miss_pulse_d;
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
            done_q          <= done_d;
        end
    end

    assign bus.drop_x        = 10'(LANE_X);
    assign bus.drop_y        = drop_y_q;
    assign bus.visible       = visible_q;
    assign bus.hit_pulse     = hit_pulse_q;
    assign bus.perfect_pulse = perfect_pulse_q;
    assign bus.miss_pulse    = miss_pulse_q;
    assign bus.hit_count     = hit_count_q;
    assign bus.miss_count    = miss_count_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_arrow_lane_dropper.sv
// Directed bench for arrow_lane_dropper: default-speed lane plus a SPEED=7 lane.
// Expected frame numbers count frames after the start key (frame 0 = first WAIT frame).
module tb_arrow_lane_dropper;
    import rhythm_pkg::*;

    localparam int NUM_NOTES = 4;
    localparam int CNT_W     = 12;

    logic frame_clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    arrow_lane_dropper_if #(.NUM_NOTES(NUM_NOTES), .CNT_W(CNT_W)) bus ();
    arrow_lane_dropper_if #(.NUM_NOTES(NUM_NOTES), .CNT_W(CNT_W)) bus7 ();

    arrow_lane_dropper #(.NUM_NOTES(NUM_NOTES), .CNT_W(CNT_W)) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    arrow_lane_dropper #(.SPEED(7), .NUM_NOTES(NUM_NOTES), .CNT_W(CNT_W)) dut7 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus7)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic step(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic set_spawn(input int s0, input int s1, input int s2, input int s3);
        bus.spawn_frames = {12'(s3), 12'(s2), 12'(s1), 12'(s0)};
    endtask

    task automatic start_run();
        bus.keycode = KEY_SPACE;
        step(1);
        bus.keycode = 8'h00;
    endtask

    task automatic restart_run();
        bus.keycode = KEY_ESC;
        step(1);
        bus.keycode = 8'h00;
    endtask

    task automatic test_reset();
        Reset               = 1'b1;
        bus.keycode         = 8'h00;
        bus.keycode_second  = 8'h00;
        bus7.keycode        = 8'h00;
        bus7.keycode_second = 8'h00;
        bus7.spawn_frames   = {12'd4000, 12'd4000, 12'd4000, 12'd0};
        set_spawn(0, 300, 600, 900);
        step(3);
        total++; if (bus.drop_y !== 10'd100) begin bad++; $display("[TB] FAIL reset_drop_y got=%0d want=100", bus.drop_y); end
        total++; if (bus.drop_x !== 10'd220) begin bad++; $display("[TB] FAIL reset_drop_x got=%0d want=220", bus.drop_x); end
        total++; if (bus.visible !== 1'b0) begin bad++; $display("[TB] FAIL reset_visible got=%0b want=0", bus.visible); end
        total++; if ({bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse} !== 3'b000) begin bad++; $display("[TB] FAIL reset_pulses got=%03b want=000", {bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse}); end
        total++; if ({bus.hit_count, bus.miss_count} !== 16'h0000) begin bad++; $display("[TB] FAIL reset_counts got=%04h want=0000", {bus.hit_count, bus.miss_count}); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0b want=0", bus.done); end
        Reset = 1'b0;
        step(4);
        total++; if (bus.visible !== 1'b0) begin bad++; $display("[TB] FAIL halted_idle_visible got=%0b want=0", bus.visible); end
    endtask

    task automatic test_all_miss();
        int first_miss = -1;
        int last_miss  = -1;
        int n_miss     = 0;
        int n_hit      = 0;
        set_spawn(0, 300, 600, 900);
        start_run();
        for (int f = 1; f <= 1200; f++) begin
            step(1);
            if (bus.miss_pulse === 1'b1) begin
                n_miss++;
                if (first_miss < 0) first_miss = f;
                last_miss = f;
            end
            if (bus.hit_pulse === 1'b1) n_hit++;
        end
        total++; if (first_miss != 262) begin bad++; $display("[TB] FAIL miss_first_frame got=%0d want=262", first_miss); end
        total++; if (last_miss != 1162) begin bad++; $display("[TB] FAIL miss_last_frame got=%0d want=1162", last_miss); end
        total++; if (n_miss != 4) begin bad++; $display("[TB] FAIL miss_pulse_count got=%0d want=4", n_miss); end
        total++; if (n_hit != 0) begin bad++; $display("[TB] FAIL miss_no_hits got=%0d want=0", n_hit); end
        total++; if (bus.miss_count !== 8'd4) begin bad++; $display("[TB] FAIL miss_count got=%0d want=4", bus.miss_count); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("[TB] FAIL miss_done got=%0b want=1", bus.done); end
        restart_run();
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL done_restart_done got=%0b want=0", bus.done); end
        total++; if (bus.miss_count !== 8'd0) begin bad++; $display("[TB] FAIL done_restart_miss_count got=%0d want=0", bus.miss_count); end
    endtask

    task automatic test_hit();
        set_spawn(0, 4000, 4000, 4000);
        start_run();
        step(1);
        total++; if ({bus.visible, bus.drop_y} !== {1'b1, 10'd100}) begin bad++; $display("[TB] FAIL spawn_vis_y got=%0b/%0d want=1/100", bus.visible, bus.drop_y); end
        step(99);
        bus.keycode = KEY_DOWN;
        step(1);
        bus.keycode = 8'h00;
        total++; if (bus.drop_y !== 10'd200) begin bad++; $display("[TB] FAIL early_key_y got=%0d want=200", bus.drop_y); end
        total++; if ({bus.visible, bus.hit_pulse, bus.miss_pulse} !== 3'b100) begin bad++; $display("[TB] FAIL early_key_ignored got=%03b want=100", {bus.visible, bus.hit_pulse, bus.miss_pulse}); end
        step(110);
        bus.keycode = KEY_DOWN;
        step(1);
        bus.keycode = 8'h00;
        total++; if ({bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse} !== 3'b100) begin bad++; $display("[TB] FAIL hit350_pulses got=%03b want=100", {bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse}); end
        total++; if (bus.hit_count !== 8'd1) begin bad++; $display("[TB] FAIL hit350_count got=%0d want=1", bus.hit_count); end
        total++; if (bus.visible !== 1'b0) begin bad++; $display("[TB] FAIL hit350_visible got=%0b want=0", bus.visible); end
        step(1);
        total++; if (bus.hit_pulse !== 1'b0) begin bad++; $display("[TB] FAIL hit_pulse_width got=%0b want=0", bus.hit_pulse); end
        restart_run();
        total++; if (bus.hit_count !== 8'd0) begin bad++; $display("[TB] FAIL hit_restart_count got=%0d want=0", bus.hit_count); end
    endtask

    task automatic test_perfect_second();
        set_spawn(0, 4000, 4000, 4000);
        start_run();
        step(231);
        bus.keycode_second = KEY_DOWN;
        step(1);
        bus.keycode_second = 8'h00;
        total++; if ({bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse} !== 3'b110) begin bad++; $display("[TB] FAIL perf370_pulses got=%03b want=110", {bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse}); end
        total++; if ({bus.hit_count, bus.miss_count} !== {8'd1, 8'd0}) begin bad++; $display("[TB] FAIL perf370_counts got=%0d/%0d want=1/0", bus.hit_count, bus.miss_count); end
        restart_run();
    endtask

    task automatic test_held_key();
        int       first_pulse = -1;
        logic [2:0] grade_seen = 3'b000;
        int       want_frame;
        logic [2:0] want_grade;
`ifdef DROPPER_KEY_EDGE_EN
        want_frame = 262;
        want_grade = 3'b001;
`else
        want_frame = 202;
        want_grade = 3'b100;
`endif
        set_spawn(0, 4000, 4000, 4000);
        bus.keycode        = KEY_SPACE;
        bus.keycode_second = KEY_DOWN;
        step(1);
        bus.keycode = 8'h00;
        for (int f = 1; f <= 300; f++) begin
            step(1);
            if (first_pulse < 0 && (bus.hit_pulse || bus.miss_pulse)) begin
                first_pulse = f;
                grade_seen  = {bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse};
            end
        end
        bus.keycode_second = 8'h00;
        total++; if (first_pulse != want_frame) begin bad++; $display("[TB] FAIL held_key_frame got=%0d want=%0d", first_pulse, want_frame); end
        total++; if (grade_seen !== want_grade) begin bad++; $display("[TB] FAIL held_key_grade got=%03b want=%03b", grade_seen, want_grade); end
        restart_run();
    endtask

    task automatic test_back_to_back();
        set_spawn(0, 0, 4000, 4000);
        start_run();
        step(211);
        bus.keycode = KEY_DOWN;
        step(1);
        bus.keycode = 8'h00;
        total++; if ({bus.hit_pulse, bus.visible} !== 2'b10) begin bad++; $display("[TB] FAIL b2b_resolve got=%02b want=10", {bus.hit_pulse, bus.visible}); end
        step(1);
        total++; if ({bus.visible, bus.drop_y, bus.hit_pulse} !== {1'b1, 10'd100, 1'b0}) begin bad++; $display("[TB] FAIL b2b_respawn got=%0b/%0d/%0b want=1/100/0", bus.visible, bus.drop_y, bus.hit_pulse); end
        step(50);
        total++; if (bus.drop_y !== 10'd150) begin bad++; $display("[TB] FAIL b2b_fall_y got=%0d want=150", bus.drop_y); end
        restart_run();
        total++; if ({bus.hit_count, bus.miss_count} !== 16'h0000) begin bad++; $display("[TB] FAIL abort_counts got=%0d/%0d want=0/0", bus.hit_count, bus.miss_count); end
        total++; if ({bus.visible, bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse, bus.done} !== 5'b00000) begin bad++; $display("[TB] FAIL abort_outputs got=%05b want=00000", {bus.visible, bus.hit_pulse, bus.perfect_pulse, bus.miss_pulse, bus.done}); end
        step(5);
        total++; if (bus.visible !== 1'b0) begin bad++; $display("[TB] FAIL abort_stays_halted got=%0b want=0", bus.visible); end
        bus.keycode        = KEY_SPACE;
        bus.keycode_second = KEY_ESC;
        step(1);
        bus.keycode        = 8'h00;
        bus.keycode_second = 8'h00;
        step(5);
        total++; if (bus.visible !== 1'b0) begin bad++; $display("[TB] FAIL start_and_restart got=%0b want=0", bus.visible); end
    endtask

    task automatic test_speed7();
        int last_y     = -1;
        int first_miss = -1;
        bus7.keycode = KEY_SPACE;
        step(1);
        bus7.keycode = 8'h00;
        for (int f = 1; f <= 60; f++) begin
            step(1);
            if (bus7.visible === 1'b1) last_y = int'(bus7.drop_y);
            if (first_miss < 0 && bus7.miss_pulse === 1'b1) first_miss = f;
        end
        total++; if (last_y != 366) begin bad++; $display("[TB] FAIL speed7_last_y got=%0d want=366", last_y); end
        total++; if (first_miss != 40) begin bad++; $display("[TB] FAIL speed7_miss_frame got=%0d want=40", first_miss); end
        total++; if ({bus7.miss_count, bus7.hit_count} !== {8'd1, 8'd0}) begin bad++; $display("[TB] FAIL speed7_counts got=%0d/%0d want=1/0", bus7.miss_count, bus7.hit_count); end
    endtask

    initial begin
        test_reset();
        test_all_miss();
        test_hit();
        test_perfect_second();
        test_held_key();
        test_back_to_back();
        test_speed7();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arrow_lane_dropper.md
Name: arrow_lane_dropper

Overview:
- Parametrised single-lane note engine for the rhythm game: schedules NUM_NOTES arrows in one lane, drops each at SPEED px/frame, and grades keypresses as perfect, hit or miss.
- Supports any lane through parameters. Sits between the keyboard keycode path and the lane renderer/score aggregator.
- Arrow bitmaps are drawn by the renderer from drop_x/drop_y/visible; this block carries no sprite data.

Parameters:
- LANE_X, 220, fixed X position of the lane
- Y_START, 100, top Y of a newly spawned arrow
- Y_MAX, 400, miss line: arrow bottom >= Y_MAX is a miss
- ARROW_H, 40, arrow height in px
- HIT_LO, 340, lowest arrow-bottom value that can score
- PERF_LO, 360 / PERF_HI, 380, perfect window on arrow bottom, inclusive lo, exclusive hi
- SPEED, 1, px added to Y per frame (1..8)
- KEY_CODE, 8'h51, lane key
- START_KEY, 8'h2c / RESTART_KEY, 8'h01
- NUM_NOTES, 4, notes per run
- CNT_W, 12, width of the frame counter and spawn times

Ports:
- frame_clk, in, 1, frame clock
- Reset, in, 1, synchronous, active-high
- keycode, in, 8, primary keycode
- keycode_second, in, 8, secondary keycode
- spawn_frames, in, NUM_NOTES*CNT_W, spawn frame of note i in bits [i*CNT_W +: CNT_W]; must be non-decreasing in i
- drop_x, out, 10, always LANE_X
- drop_y, out, 10, top Y of the active arrow
- visible, out, 1, active arrow is drawn
- hit_pulse / perfect_pulse / miss_pulse, out, 1 each, one-frame grade strobes
- hit_count / miss_count, out, 8 each, saturating totals; hit_count includes perfects
- done, out, 1, run finished

Behaviour:
- Reset: state HALTED; counter, index, both counts and all pulses = 0; drop_y = Y_START; visible = 0; done = 0.
- States:
  - HALTED: counter, index and counts held at 0. Start key present on either keycode input -> WAIT. Counter is 0 on the first WAIT frame.
  - WAIT: counter increments every frame and saturates at 2^CNT_W-1. When counter >= spawn[index] -> FALL, with drop_y = Y_START and visible = 1 on the first FALL frame.
  - FALL: counter keeps running. Each frame, using the registered drop_y, bottom = drop_y + ARROW_H computed at 11 bits so it cannot wrap. Priority:
    1. bottom >= Y_MAX -> miss
    2. else key match and bottom >= HIT_LO -> hit; perfect if PERF_LO <= bottom < PERF_HI
    3. else drop_y += SPEED
    - Key match = KEY_CODE present on keycode or keycode_second.
    - On any resolution: visible = 0 next frame; matching pulse(s) high for exactly that one frame (perfect_pulse and hit_pulse together for a perfect); counts increment, saturating at 255; index += 1. Then go to DONE if index == NUM_NOTES, else WAIT.
    - If the next spawn time has already passed, FALL is re-entered one frame later.
  - DONE: done = 1, visible = 0, counts held. Restart key -> HALTED.
- Restart key in WAIT or FALL aborts the run: -> HALTED next frame, counts cleared, no pulse.
- Simultaneous events:
  - Key on the frame bottom reaches Y_MAX -> miss.
  - Start and restart keys both present in HALTED -> stay HALTED.
- Key with bottom < HIT_LO: ignored, and the arrow continues falling.

Optional Feature:
- DROPPER_KEY_EDGE_EN
  - Defined: a key match counts only on the first frame it appears, i.e. it was absent on both keycode inputs in the previous frame (one extra registered flag). A held key can score at most one note and cannot pre-arm the hit window.
  - Undefined: key match is level-sensitive. Holding the key scores every note on its first frame with bottom >= HIT_LO.

Decomposition:
- Package rhythm_pkg holds:
  - state enum (HALTED, WAIT, FALL, DONE)
  - grade typedef (NONE, MISS, HIT, PERFECT)
  - keycode constants (KEY_SPACE = 8'h2c, KEY_ESC = 8'h01, lane keys)
  - screen constants (Y_MAX default, ARROW_H)
- One sub-module, lane_key_detect: two-input keycode match plus the optional edge register. Outputs key_hit, start_req and restart_req.

Test Plan:
- Reset, start key, spawn = {0, 300, 600, 900}, no keys -> four miss_pulses; first fires when drop_y = 360, roughly frame 261; miss_count = 4; then done = 1.
- Note 0: key 8'h51 applied when bottom = 350 -> hit_pulse = 1, perfect_pulse = 0, hit_count = 1, visible drops the next frame.
- Key on keycode_second when bottom = 370 -> hit_pulse and perfect_pulse both = 1.
- Key held from spawn with DROPPER_KEY_EDGE_EN defined -> miss at bottom 400. Without the macro -> hit at bottom 340.
- Restart key 8'h01 mid-FALL -> HALTED next frame, counts = 0, no pulse. Spawn = {0, 0, ...} -> note 1 enters FALL the frame after note 0 resolves.
- SPEED = 7 and key never pressed -> miss when bottom first reaches or passes 400 (bottom 406 with no wrap), miss_count = 1.
